// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a credit-limited, pipelined imem port and an
// in-order prefetch queue feeding decode through a valid/ready hand-off.
// Redirects flush the queue and mark outstanding responses as stale.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] WORD_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [CNT_W-1:0]   inflight_r, drop_r, occ_r;
  logic [CNT_W-1:0]   inflight_nx_s, drop_nx_s, occ_nx_s;
  logic [ADDR_W-1:0]  pcf_mem_r [DEPTH];
  logic [PTR_W-1:0]   pcf_rd_r, pcf_wr_r;
  logic [ADDR_W-1:0]  iq_pc4_r [DEPTH];
  logic [INSTR_W-1:0] iq_instr_r [DEPTH];
  logic [PTR_W-1:0]   iq_rd_r, iq_wr_r;

  logic credit_s, req_valid_s, accept_s;
  logic rsp_live_s, rsp_keep_s, id_valid_s, pop_s;

  // Credits cover both queued entries and every outstanding request,
  // including ones whose responses will be thrown away.
  assign credit_s    = ({1'b0, inflight_r} + {1'b0, occ_r}) < {1'b0, DEPTH_C};
  assign req_valid_s = rst_n & ~redirect_valid & credit_s;
  assign accept_s    = req_valid_s & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live_s  = imem_rsp_valid & (inflight_r != {CNT_W{1'b0}});
  assign rsp_keep_s  = rsp_live_s & ~redirect_valid & (drop_r == {CNT_W{1'b0}});
  assign id_valid_s  = (occ_r != {CNT_W{1'b0}});
  assign pop_s       = id_valid_s & id_ready & ~redirect_valid;

  assign imem_req_valid = req_valid_s;
  assign imem_addr      = fetch_pc_r;
  assign id_valid       = id_valid_s;
  assign id_pc_plus4    = iq_pc4_r[iq_rd_r];
  assign id_instr       = iq_instr_r[iq_rd_r];

  // Next values of the inflight, drop and occupancy counters.
  always_comb begin
    inflight_nx_s = inflight_r;
    drop_nx_s     = drop_r;
    occ_nx_s      = occ_r;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle is stale, so the drop
      // count simply becomes the remaining inflight count.
      inflight_nx_s = inflight_r - CNT_W'(rsp_live_s);
      drop_nx_s     = inflight_r - CNT_W'(rsp_live_s);
      occ_nx_s      = {CNT_W{1'b0}};
    end else begin
      inflight_nx_s = inflight_r + CNT_W'(accept_s) - CNT_W'(rsp_live_s);
      if (rsp_live_s && (drop_r != {CNT_W{1'b0}})) begin
        drop_nx_s = drop_r - CNT_W'(1'b1);
      end else begin
        drop_nx_s = drop_r;
      end
      occ_nx_s = occ_r + CNT_W'(rsp_keep_s) - CNT_W'(pop_s);
    end
  end

  // Fetch PC and the three bookkeeping counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      inflight_r <= {CNT_W{1'b0}};
      drop_r     <= {CNT_W{1'b0}};
      occ_r      <= {CNT_W{1'b0}};
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc & WORD_MSK;
      end else if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      inflight_r <= inflight_nx_s;
      drop_r     <= drop_nx_s;
      occ_r      <= occ_nx_s;
    end
  end

  // PC FIFO: addresses of live outstanding requests, matched to responses in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_rd_r <= {PTR_W{1'b0}};
      pcf_wr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pcf_mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (redirect_valid) begin
      pcf_rd_r <= {PTR_W{1'b0}};
      pcf_wr_r <= {PTR_W{1'b0}};
    end else begin
      if (accept_s) begin
        pcf_mem_r[pcf_wr_r] <= fetch_pc_r;
        pcf_wr_r            <= ptr_inc(pcf_wr_r);
      end
      if (rsp_keep_s) begin
        pcf_rd_r <= ptr_inc(pcf_rd_r);
      end
    end
  end

  // Instruction queue of {pc+4, instr}; decode reads the head straight from storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_rd_r <= {PTR_W{1'b0}};
      iq_wr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        iq_pc4_r[i]   <= {ADDR_W{1'b0}};
        iq_instr_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (redirect_valid) begin
      iq_rd_r <= {PTR_W{1'b0}};
      iq_wr_r <= {PTR_W{1'b0}};
    end else begin
      if (rsp_keep_s) begin
        iq_pc4_r[iq_wr_r]   <= pcf_mem_r[pcf_rd_r] + PC_STEP;
        iq_instr_r[iq_wr_r] <= imem_rsp_data;
        iq_wr_r             <= ptr_inc(iq_wr_r);
      end
      if (pop_s) begin
        iq_rd_r <= ptr_inc(iq_rd_r);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a latency-configurable memory model,
// a scoreboard of expected decode entries and a decoupled decode monitor.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  if_fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc + 32'd4, instr_of(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Memory model: fixed latency lat, in order, one response per accepted request.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
      end
    end
  end

  // Decode monitor: every hand-off is checked against the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (rst_n && id_valid && id_ready && !redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: decode took pc_plus4 0x%08h with nothing expected", id_pc_plus4);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc_plus4", id_pc_plus4, e[63:32]);
        chk("sb_instr", id_instr, e[31:0]);
      end
    end
  end

  initial begin
    int reqs;
    int p0;
    int bubbles;
    int waited;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; id_ready = 1'b1; lat = 1;

    // Reset values
    repeat (3) @(negedge clk);
    #3;
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_id_valid", id_valid, 32'd0);
    chk("rst_pc_plus4", id_pc_plus4, 32'h0);
    chk("rst_instr", id_instr, 32'h0);

    // Streaming from reset, k=1
    @(negedge clk); rst_n = 1'b1; expect_stream(32'h0, 64);
    #3;
    chk("c0_req_valid", imem_req_valid, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_id_valid", id_valid, 32'd0);
    @(negedge clk); #3;
    chk("c1_id_valid", id_valid, 32'd0);
    chk("c1_addr", imem_addr, 32'h4);
    @(negedge clk); #3;
    chk("c2_id_valid", id_valid, 32'd1);
    chk("c2_pc_plus4", id_pc_plus4, 32'h4);
    chk("c2_instr", id_instr, instr_of(32'h0));
    bubbles = 0;
    repeat (20) begin
      @(negedge clk); #3;
      if (!id_valid) bubbles++;
    end
    chk("stream_bubbles", bubbles, 32'd0);

    // Redirect with a live response and a pop in the same cycle, then stall decode
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    exp_q.delete(); expect_stream(32'h200, 64);
    #3;
    chk("rd_head_valid", id_valid, 32'd1);
    chk("rd_no_req", imem_req_valid, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b0;
    #3;
    chk("rd_next_id_valid", id_valid, 32'd0);
    chk("rd_next_addr", imem_addr, 32'h200);
    reqs = (imem_req_valid && imem_req_ready) ? 1 : 0;
    repeat (9) begin
      @(negedge clk); #3;
      if (imem_req_valid && imem_req_ready) reqs++;
    end
    chk("stall_reqs", reqs, 32'd4);
    chk("stall_req_valid", imem_req_valid, 32'd0);
    chk("stall_id_valid", id_valid, 32'd1);
    chk("stall_head", id_pc_plus4, 32'h204);
    p0 = pops;
    repeat (12) begin
      @(negedge clk); id_ready = 1'b1;
    end
    #3;
    chk("resume_pops", pops - p0, 32'd12);

    // Drain, then redirect with 3 in flight at k=3
    @(negedge clk); imem_req_ready = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h300; exp_q.delete(); lat = 3;
    @(negedge clk); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #3;
    chk("k3_addr", imem_addr, 32'h300);
    chk("k3_req_valid", imem_req_valid, 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    exp_q.delete(); expect_stream(32'h100, 64);
    #3;
    chk("k3_rd_no_req", imem_req_valid, 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    #3;
    chk("k3_new_addr", imem_addr, 32'h100);
    chk("k3_new_req_valid", imem_req_valid, 32'd1);
    chk("k3_id_flushed", id_valid, 32'd0);
    repeat (3) @(negedge clk);
    #3;
    chk("k3_not_early", id_valid, 32'd0);
    @(negedge clk); #3;
    chk("k3_first_valid", id_valid, 32'd1);
    chk("k3_first_pc4", id_pc_plus4, 32'h104);

    // Address wrap
    repeat (6) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete(); expect_stream(32'hFFFF_FFFC, 64);
    @(negedge clk); redirect_valid = 1'b0;
    #3;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    waited = 0;
    while (!(imem_req_valid && imem_req_ready) && waited < 8) begin
      @(negedge clk); #3;
      waited++;
    end
    chk("wrap_accept_in_time", (waited < 8) ? 32'd1 : 32'd0, 32'd1);
    p0 = pops;
    @(negedge clk); #3;
    chk("wrap_addr_zero", imem_addr, 32'h0);
    repeat (10) @(negedge clk);
    #3;
    chk("wrap_delivered", (pops - p0 >= 2) ? 32'd1 : 32'd0, 32'd1);

    // Fill the queue, then reset asynchronously mid-cycle
    @(negedge clk); id_ready = 1'b0;
    repeat (9) @(negedge clk);
    #3;
    chk("full_id_valid", id_valid, 32'd1);
    chk("full_req_valid", imem_req_valid, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", imem_req_valid, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_id_valid", id_valid, 32'd0);
    chk("arst_pc_plus4", id_pc_plus4, 32'h0);
    chk("arst_instr", id_instr, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; lat = 1; id_ready = 1'b1; expect_stream(32'h0, 64);
    p0 = pops;
    #3;
    chk("rerun_addr", imem_addr, 32'h0);
    chk("rerun_req_valid", imem_req_valid, 32'd1);
    repeat (9) @(negedge clk);
    #3;
    chk("rerun_pops", pops - p0, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
